// File: rtl/button_evt_pkg.sv
// rtl/button_evt_pkg.sv - shared constants and arbiter state type for the button event arbiter
package button_evt_pkg;

  localparam int NUM_BTN_MAX = 8;

  localparam logic EVT_PRESS = 1'b0;
  localparam logic EVT_LONG  = 1'b1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

endpackage

// File: rtl/button_event_arbiter_if.sv
// rtl/button_event_arbiter_if.sv - event handshake bundle between arbiter and consumer
interface button_event_arbiter_if;

  logic       evt_valid;
  logic [2:0] evt_id;
  logic       evt_long;
  logic       evt_ready;

  modport master (
    output evt_valid,
    output evt_id,
    output evt_long,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_id,
    input  evt_long,
    output evt_ready
  );

endinterface

// File: rtl/btn_hold_timer.sv
// rtl/btn_hold_timer.sv - per-button edge detect, long-hold timer and pending event flags
module btn_hold_timer #(
  parameter int HOLD_CYCLES = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  input  logic clr_press,
  input  logic clr_long,
  output logic pend_press,
  output logic pend_long,
  output logic overflow
);

  localparam int CW = $clog2(HOLD_CYCLES);
  // Counter parks here once the long press has been reported.
  localparam logic [CW-1:0] CNT_SAT  = CW'(HOLD_CYCLES - 1);
  // Stepping from this value to CNT_SAT is the cycle the long press fires.
  localparam logic [CW-1:0] CNT_FIRE = CW'(HOLD_CYCLES - 2);

  logic          btn_q;
  logic [CW-1:0] hold_cnt;
  logic          press_evt;
  logic          long_evt;

  assign press_evt = btn_in && !btn_q;
  assign long_evt  = btn_in && btn_q && (hold_cnt == CNT_FIRE);

  // Track previous level and count consecutive held cycles; reset tracks the level so a held button does not re-press.
  always_ff @(posedge clk) begin
    btn_q <= btn_in;
    if (rst || !btn_in || press_evt) begin
      hold_cnt <= '0;
    end else if (hold_cnt != CNT_SAT) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  // Pending flags: a fresh event overrides a same-cycle grant; a repeat on a still-pending flag is dropped and recorded.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_press <= 1'b0;
      pend_long  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (press_evt) begin
        if (pend_press && !clr_press) overflow <= 1'b1;
        pend_press <= 1'b1;
      end else if (clr_press) begin
        pend_press <= 1'b0;
      end
      if (long_evt) begin
        if (pend_long && !clr_long) overflow <= 1'b1;
        pend_long <= 1'b1;
      end else if (clr_long) begin
        pend_long <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/button_event_arbiter.sv
// rtl/button_event_arbiter.sv - serializes per-button press and long-press events round-robin onto a valid/ready stream
module button_event_arbiter
  import button_evt_pkg::*;
#(
  parameter int NUM_BTN     = 5,
  parameter int HOLD_CYCLES = 25000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_BTN-1:0]            btn_in,
  button_event_arbiter_if.master        evt,
  output logic [NUM_BTN-1:0]            pending,
  output logic [NUM_BTN-1:0]            overflow
);

  localparam int IW = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;

  logic [NUM_BTN-1:0] pend_press;
  logic [NUM_BTN-1:0] pend_long;
  logic [NUM_BTN-1:0] clr_press;
  logic [NUM_BTN-1:0] clr_long;

  arb_state_t state;
  logic [2:0] last_grant;
  logic [2:0] id_q;
  logic       long_q;

  logic          grant_found;
  logic [2:0]    grant_idx;
  logic          grant_long;
  logic [IW-1:0] cand;
  int            idx;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_hold_timer #(
      .HOLD_CYCLES(HOLD_CYCLES)
    ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .btn_in    (btn_in[i]),
      .clr_press (clr_press[i]),
      .clr_long  (clr_long[i]),
      .pend_press(pend_press[i]),
      .pend_long (pend_long[i]),
      .overflow  (overflow[i])
    );
  end

  assign pending = pend_press | pend_long;

  // Round-robin scan starting one past the last grant; press beats long within a button to keep chronological order.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_long  = EVT_PRESS;
    cand        = '0;
    idx         = 0;
    for (int k = 1; k <= NUM_BTN; k++) begin
      idx  = (int'(last_grant) + k) % NUM_BTN;
      cand = IW'(idx);
      if (!grant_found && pending[cand]) begin
        grant_found = 1'b1;
        grant_idx   = 3'(idx);
        grant_long  = pend_press[cand] ? EVT_PRESS : EVT_LONG;
      end
    end
  end

  // Clear exactly the flag being granted, only when the arbiter actually takes it.
  always_comb begin
    clr_press = '0;
    clr_long  = '0;
    if (state == IDLE && grant_found) begin
      if (grant_long == EVT_LONG) clr_long[IW'(grant_idx)]  = 1'b1;
      else                        clr_press[IW'(grant_idx)] = 1'b1;
    end
  end

  // Arbiter: latch one event per grant and hold it until the consumer accepts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 3'(NUM_BTN - 1);
      id_q       <= '0;
      long_q     <= EVT_PRESS;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            state      <= OFFER;
            id_q       <= grant_idx;
            long_q     <= grant_long;
            last_grant <= grant_idx;
          end
        end
        OFFER: begin
          if (evt.evt_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign evt.evt_valid = (state == OFFER);
  assign evt.evt_id    = id_q;
  assign evt.evt_long  = long_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// tb/tb_button_event_arbiter.sv - self-checking bench for button_event_arbiter
module tb_button_event_arbiter;

  localparam int NB   = 5;
  localparam int HOLD = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn = '0;
  logic          ready = 1'b0;
  logic [NB-1:0] pending;
  logic [NB-1:0] overflow;

  int n_pass  = 0;
  int n_total = 0;

  button_event_arbiter_if evt_if ();
  assign evt_if.evt_ready = ready;

  button_event_arbiter #(
    .NUM_BTN    (NB),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_in  (btn),
    .evt     (evt_if),
    .pending (pending),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: level history, run length of the current hold, pending flags, offered event.
  bit m_q   [NB];
  int m_run [NB];
  bit m_pp  [NB];
  bit m_pl  [NB];
  bit m_ov  [NB];
  bit m_offer;
  int m_id;
  bit m_long;
  int m_last;

  task automatic model_edge();
    bit press, lng;
    if (rst) begin
      for (int i = 0; i < NB; i++) begin
        m_q[i] = btn[i]; m_run[i] = btn[i] ? 1 : 0;
        m_pp[i] = 0; m_pl[i] = 0; m_ov[i] = 0;
      end
      m_offer = 0; m_id = 0; m_long = 0; m_last = NB - 1;
    end else begin
      if (m_offer) begin
        if (ready) m_offer = 0;
      end else begin
        for (int k = 1; k <= NB; k++) begin
          int b;
          b = (m_last + k) % NB;
          if (m_pp[b] || m_pl[b]) begin
            m_offer = 1; m_id = b; m_long = !m_pp[b]; m_last = b;
            if (m_pp[b]) m_pp[b] = 0; else m_pl[b] = 0;
            break;
          end
        end
      end
      for (int i = 0; i < NB; i++) begin
        press = btn[i] && !m_q[i];
        lng = 0;
        if (press) m_run[i] = 1;
        else if (btn[i]) begin
          if (m_run[i] < HOLD) begin
            m_run[i]++;
            lng = (m_run[i] == HOLD);
          end
        end else m_run[i] = 0;
        if (press) begin if (m_pp[i]) m_ov[i] = 1; m_pp[i] = 1; end
        if (lng)   begin if (m_pl[i]) m_ov[i] = 1; m_pl[i] = 1; end
        m_q[i] = btn[i];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    btn = '0; ready = 1'b0;
    do_reset();
    step();
    n_total++; if (evt_if.evt_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", evt_if.evt_valid); else n_pass++;
    n_total++; if (evt_if.evt_id !== 3'd0) $display("FAIL reset_id: got %0d want 0", evt_if.evt_id); else n_pass++;
    n_total++; if (evt_if.evt_long !== 1'b0) $display("FAIL reset_long: got %b want 0", evt_if.evt_long); else n_pass++;
    n_total++; if (pending !== 5'b00000) $display("FAIL reset_pending: got %b want 00000", pending); else n_pass++;
    n_total++; if (overflow !== 5'b00000) $display("FAIL reset_overflow: got %b want 00000", overflow); else n_pass++;
  endtask

  task automatic test_single_press();
    int nval;
    btn = '0; ready = 1'b1;
    do_reset();
    step();
    btn = 5'b00100;
    step();
    btn = '0;
    n_total++; if (evt_if.evt_valid !== 1'b0 || pending !== 5'b00100) $display("FAIL single_latency1: got valid=%b pending=%b want valid=0 pending=00100", evt_if.evt_valid, pending); else n_pass++;
    step();
    n_total++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 3'd2 || evt_if.evt_long !== 1'b0) $display("FAIL single_event: got valid=%b id=%0d long=%b want 1/2/0", evt_if.evt_valid, evt_if.evt_id, evt_if.evt_long); else n_pass++;
    nval = 0;
    repeat (6) begin step(); if (evt_if.evt_valid) nval++; end
    n_total++; if (nval !== 0) $display("FAIL single_pulse: got %0d extra valid cycles want 0", nval); else n_pass++;
  endtask

  task automatic test_long_hold();
    int ev_k[$]; int ev_id[$]; bit ev_l[$];
    btn = '0; ready = 1'b1;
    do_reset();
    btn = 5'b00001;
    for (int k = 0; k < 30; k++) begin
      if (k == 21) btn = '0;
      step();
      if (evt_if.evt_valid) begin ev_k.push_back(k); ev_id.push_back(int'(evt_if.evt_id)); ev_l.push_back(evt_if.evt_long); end
    end
    n_total++; if (ev_k.size() != 2) $display("FAIL long_count: got %0d events want 2", ev_k.size()); else n_pass++;
    if (ev_k.size() == 2) begin
      n_total++; if (ev_k[0] != 1 || ev_id[0] != 0 || ev_l[0] !== 1'b0) $display("FAIL long_press_evt: got k=%0d id=%0d long=%b want 1/0/0", ev_k[0], ev_id[0], ev_l[0]); else n_pass++;
      n_total++; if (ev_k[1] != 8 || ev_id[1] != 0 || ev_l[1] !== 1'b1) $display("FAIL long_long_evt: got k=%0d id=%0d long=%b want 8/0/1", ev_k[1], ev_id[1], ev_l[1]); else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    int ev_k[$]; int ev_id[$];
    btn = '0; ready = 1'b1;
    do_reset();
    btn = 5'b10011;
    for (int k = 0; k < 10; k++) begin
      step();
      btn = '0;
      if (evt_if.evt_valid) begin ev_k.push_back(k); ev_id.push_back(int'(evt_if.evt_id)); end
    end
    n_total++; if (ev_k.size() != 3) $display("FAIL rr1_count: got %0d want 3", ev_k.size()); else n_pass++;
    if (ev_k.size() == 3) begin
      n_total++; if (ev_id[0] != 0 || ev_id[1] != 1 || ev_id[2] != 4) $display("FAIL rr1_order: got %0d,%0d,%0d want 0,1,4", ev_id[0], ev_id[1], ev_id[2]); else n_pass++;
      n_total++; if (ev_k[0] != 1 || ev_k[1] != 3 || ev_k[2] != 5) $display("FAIL rr1_spacing: got %0d,%0d,%0d want 1,3,5", ev_k[0], ev_k[1], ev_k[2]); else n_pass++;
    end
    ev_k.delete(); ev_id.delete();
    btn = 5'b10010;
    for (int k = 0; k < 8; k++) begin
      step();
      btn = '0;
      if (evt_if.evt_valid) begin ev_k.push_back(k); ev_id.push_back(int'(evt_if.evt_id)); end
    end
    n_total++; if (ev_k.size() != 2) $display("FAIL rr2_count: got %0d want 2", ev_k.size()); else n_pass++;
    if (ev_k.size() == 2) begin
      n_total++; if (ev_id[0] != 1 || ev_id[1] != 4) $display("FAIL rr2_order: got %0d,%0d want 1,4", ev_id[0], ev_id[1]); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int n3, nother;
    btn = '0; ready = 1'b0;
    do_reset();
    btn = 5'b01000; step();
    btn = '0;       step();
    n_total++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 3'd3 || pending !== 5'b00000) $display("FAIL bp_offer: got valid=%b id=%0d pending=%b want 1/3/00000", evt_if.evt_valid, evt_if.evt_id, pending); else n_pass++;
    btn = 5'b01000; step();
    n_total++; if (pending !== 5'b01000 || overflow !== 5'b00000) $display("FAIL bp_repend: got pending=%b overflow=%b want 01000/00000", pending, overflow); else n_pass++;
    btn = '0;       step();
    btn = 5'b01000; step();
    n_total++; if (overflow !== 5'b01000) $display("FAIL bp_overflow: got %b want 01000", overflow); else n_pass++;
    btn = '0;
    repeat (2) step();
    n_total++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 3'd3 || evt_if.evt_long !== 1'b0) $display("FAIL bp_stable: got valid=%b id=%0d long=%b want 1/3/0", evt_if.evt_valid, evt_if.evt_id, evt_if.evt_long); else n_pass++;
    ready = 1'b1;
    n3 = 0; nother = 0;
    repeat (8) begin
      if (evt_if.evt_valid && ready) begin
        if (evt_if.evt_id == 3'd3 && evt_if.evt_long == 1'b0) n3++; else nother++;
      end
      step();
    end
    n_total++; if (n3 != 2 || nother != 0) $display("FAIL bp_drain: got %0d btn3 presses and %0d others want 2/0", n3, nother); else n_pass++;
    n_total++; if (overflow !== 5'b01000) $display("FAIL bp_sticky: got %b want 01000", overflow); else n_pass++;
  endtask

  task automatic test_reset_hold();
    int ev_k[$]; int ev_id[$]; bit ev_l[$];
    btn = 5'b00010; ready = 1'b1;
    do_reset();
    for (int k = 0; k < 15; k++) begin
      step();
      if (k == 0) begin
        n_total++; if (evt_if.evt_valid !== 1'b0 || pending !== 5'b00000 || overflow !== 5'b00000) $display("FAIL rsthold_clean: got valid=%b pending=%b overflow=%b want 0/00000/00000", evt_if.evt_valid, pending, overflow); else n_pass++;
      end
      if (evt_if.evt_valid) begin ev_k.push_back(k); ev_id.push_back(int'(evt_if.evt_id)); ev_l.push_back(evt_if.evt_long); end
    end
    btn = '0;
    n_total++; if (ev_k.size() != 1) $display("FAIL rsthold_count: got %0d events want 1", ev_k.size()); else n_pass++;
    if (ev_k.size() == 1) begin
      n_total++; if (ev_k[0] != HOLD - 1 || ev_id[0] != 1 || ev_l[0] !== 1'b1) $display("FAIL rsthold_long: got k=%0d id=%0d long=%b want %0d/1/1", ev_k[0], ev_id[0], ev_l[0], HOLD - 1); else n_pass++;
    end
    repeat (3) step();
  endtask

  task automatic test_collision();
    int n2;
    btn = '0; ready = 1'b0;
    do_reset();
    btn = 5'b00001; step();
    btn = 5'b00100; step();
    btn = '0;
    repeat (2) step();
    ready = 1'b1;   step();
    btn = 5'b00100; step();
    n_total++; if (pending !== 5'b00100 || overflow !== 5'b00000) $display("FAIL coll_flags: got pending=%b overflow=%b want 00100/00000", pending, overflow); else n_pass++;
    n_total++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 3'd2) $display("FAIL coll_offer: got valid=%b id=%0d want 1/2", evt_if.evt_valid, evt_if.evt_id); else n_pass++;
    btn = '0;
    n2 = 0;
    repeat (6) begin
      if (evt_if.evt_valid && ready && evt_if.evt_id == 3'd2) n2++;
      step();
    end
    n_total++; if (n2 != 2) $display("FAIL coll_events: got %0d button-2 events want 2", n2); else n_pass++;
  endtask

  task automatic test_random();
    logic [NB-1:0] ep, eo;
    btn = '0; ready = 1'b1;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NB; i++) if ($urandom_range(0, 9) == 0) btn[i] = ~btn[i];
      ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 249) == 0);
      step();
      for (int i = 0; i < NB; i++) begin ep[i] = m_pp[i] | m_pl[i]; eo[i] = m_ov[i]; end
      n_total++; if (evt_if.evt_valid !== m_offer) $display("FAIL rnd_valid c=%0d: got %b want %b", c, evt_if.evt_valid, m_offer); else n_pass++;
      n_total++; if (evt_if.evt_id !== 3'(m_id)) $display("FAIL rnd_id c=%0d: got %0d want %0d", c, evt_if.evt_id, m_id); else n_pass++;
      n_total++; if (evt_if.evt_long !== m_long) $display("FAIL rnd_long c=%0d: got %b want %b", c, evt_if.evt_long, m_long); else n_pass++;
      n_total++; if (pending !== ep) $display("FAIL rnd_pending c=%0d: got %b want %b", c, pending, ep); else n_pass++;
      n_total++; if (overflow !== eo) $display("FAIL rnd_overflow c=%0d: got %b want %b", c, overflow, eo); else n_pass++;
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_long_hold();
    test_round_robin();
    test_backpressure();
    test_reset_hold();
    test_collision();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
